max_finder_stream: RTL and testbench

Streaming, framed successor to the combinational max finder. It accepts one WIDTH-bit sample per handshake on a valid/ready input stream, with frames delimited by `in_last`. For each frame it reports the maximum value, the index of its first occurrence, and the frame length on a valid/ready result port. It sits between sample producers (ADC/DSP front ends) and the peak-detection logic, replacing wide combinational trees when samples arrive serially.

---
 rtl/max_finder_stream.sv | 209 ++++++++++++++++++++
 tb/tb_max_finder_stream.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_finder_stream.sv
// -----------------------------------------------------------------------------
// max_finder_stream
//   Framed streaming peak finder. Samples arrive one per valid/ready handshake,
//   frames are delimited by in_last. For every frame the block reports the
//   maximum value, the beat index of its first occurrence, the (saturating)
//   beat count and an overflow flag on a valid/ready result port.
//
// Parameters
//   WIDTH   : sample width in bits
//   MAX_LEN : longest supported frame in beats; beats beyond it are counted
//             as overflow and do not take part in the comparison
//   SIGNED  : 1 = two's-complement compare, 0 = unsigned compare
//
// Ports
//   clk, rst_n             : clock, synchronous active-low reset
//   in_valid/in_ready      : sample handshake, in_data sample, in_last end of frame
//   out_valid/out_ready    : result handshake
//   out_max, out_idx       : frame maximum and index of its first occurrence
//   out_count, out_err     : beats counted (saturating at MAX_LEN), overflow flag
//   out_min, out_min_idx   : frame minimum and its first index
//                            (only when MAX_FINDER_STREAM_MIN_EN is defined)
//
// Optional feature macro: MAX_FINDER_STREAM_MIN_EN
// -----------------------------------------------------------------------------
module max_finder_stream #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 256,
    parameter int SIGNED  = 0,
    localparam int IDXW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int CNTW   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [IDXW-1:0]  out_idx,
    output logic [CNTW-1:0]  out_count,
`ifdef MAX_FINDER_STREAM_MIN_EN
    output logic [WIDTH-1:0] out_min,
    output logic [IDXW-1:0]  out_min_idx,
`endif
    output logic             out_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // True when a is strictly greater than b under the configured signedness.
    function automatic logic is_greater(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
        logic res;
        if (SIGNED != 0) begin
            res = ($signed(a) > $signed(b));
        end else begin
            res = (a > b);
        end
        return res;
    endfunction

    logic [1:0]       r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_max;
    logic [IDXW-1:0]  r_idx;
    logic [CNTW-1:0]  r_count;
    logic             r_err;

    logic [1:0]       w_nxt_state;
    logic [WIDTH-1:0] w_nxt_max;
    logic [IDXW-1:0]  w_nxt_idx;
    logic [CNTW-1:0]  w_nxt_count;
    logic             w_nxt_err;
    logic             w_accept;
    logic             w_in_range;
    logic [IDXW-1:0]  w_beat_idx;

`ifdef MAX_FINDER_STREAM_MIN_EN
    logic [WIDTH-1:0] r_min;
    logic [IDXW-1:0]  r_min_idx;
    logic [WIDTH-1:0] w_nxt_min;
    logic [IDXW-1:0]  w_nxt_min_idx;
`endif

    // in_ready is a pure decode of the registered state, gated low during reset.
    assign in_ready   = rst_n && (r_state != ST_HOLD);
    assign w_accept   = in_valid && in_ready;
    // Beats at or beyond MAX_LEN only raise the overflow flag.
    assign w_in_range = (r_count < CNTW'(MAX_LEN));
    // r_count is the index of the beat being accepted; it fits IDXW whenever in range.
    assign w_beat_idx = IDXW'(r_count);

    // Frame state machine and running max/min/count update.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_max   = r_max;
        w_nxt_idx   = r_idx;
        w_nxt_count = r_count;
        w_nxt_err   = r_err;
`ifdef MAX_FINDER_STREAM_MIN_EN
        w_nxt_min     = r_min;
        w_nxt_min_idx = r_min_idx;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nxt_max   = in_data;
                    w_nxt_idx   = {IDXW{1'b0}};
                    w_nxt_count = CNTW'(1'b1);
                    w_nxt_err   = 1'b0;
`ifdef MAX_FINDER_STREAM_MIN_EN
                    w_nxt_min     = in_data;
                    w_nxt_min_idx = {IDXW{1'b0}};
`endif
                    if (in_last) begin
                        w_nxt_state = ST_HOLD;
                    end else begin
                        w_nxt_state = ST_ACCUM;
                    end
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    if (w_in_range) begin
                        // Strict compare keeps the earliest index on ties.
                        if (is_greater(in_data, r_max)) begin
                            w_nxt_max = in_data;
                            w_nxt_idx = w_beat_idx;
                        end else begin
                            w_nxt_max = r_max;
                        end
`ifdef MAX_FINDER_STREAM_MIN_EN
                        if (is_greater(r_min, in_data)) begin
                            w_nxt_min     = in_data;
                            w_nxt_min_idx = w_beat_idx;
                        end else begin
                            w_nxt_min = r_min;
                        end
`endif
                        w_nxt_count = r_count + CNTW'(1'b1);
                    end else begin
                        w_nxt_err = 1'b1;
                    end
                    if (in_last) begin
                        w_nxt_state = ST_HOLD;
                    end else begin
                        w_nxt_state = ST_ACCUM;
                    end
                end else begin
                    w_nxt_state = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_nxt_state = ST_HOLD;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_max       <= {WIDTH{1'b0}};
            r_idx       <= {IDXW{1'b0}};
            r_count     <= {CNTW{1'b0}};
            r_err       <= 1'b0;
`ifdef MAX_FINDER_STREAM_MIN_EN
            r_min       <= {WIDTH{1'b0}};
            r_min_idx   <= {IDXW{1'b0}};
`endif
        end else begin
            r_state     <= w_nxt_state;
            r_out_valid <= (w_nxt_state == ST_HOLD);
            r_max       <= w_nxt_max;
            r_idx       <= w_nxt_idx;
            r_count     <= w_nxt_count;
            r_err       <= w_nxt_err;
`ifdef MAX_FINDER_STREAM_MIN_EN
            r_min       <= w_nxt_min;
            r_min_idx   <= w_nxt_min_idx;
`endif
        end
    end

    assign out_valid = r_out_valid;
    assign out_max   = r_max;
    assign out_idx   = r_idx;
    assign out_count = r_count;
    assign out_err   = r_err;
`ifdef MAX_FINDER_STREAM_MIN_EN
    assign out_min     = r_min;
    assign out_min_idx = r_min_idx;
`endif

endmodule

// File: tb/tb_max_finder_stream.sv
// -----------------------------------------------------------------------------
// tb_max_finder_stream
//   Three instances share one input stream: default (unsigned, MAX_LEN=256),
//   signed, and MAX_LEN=4. Expected results come from a list-based model of
//   each frame.
// -----------------------------------------------------------------------------
module tb_max_finder_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic [7:0] in_data;

    logic       rdy_a, val_a, err_a;
    logic [7:0] max_a, idx_a;
    logic [8:0] cnt_a;
    logic       rdy_b, val_b, err_b;
    logic [7:0] max_b, idx_b;
    logic [8:0] cnt_b;
    logic       rdy_c, val_c, err_c;
    logic [7:0] max_c;
    logic [1:0] idx_c;
    logic [2:0] cnt_c;
`ifdef MAX_FINDER_STREAM_MIN_EN
    logic [7:0] min_a, midx_a, min_b, midx_b, min_c;
    logic [1:0] midx_c;
`endif

    max_finder_stream #(.WIDTH(8), .MAX_LEN(256), .SIGNED(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .in_last(in_last), .out_valid(val_a), .out_ready(out_ready),
        .out_max(max_a), .out_idx(idx_a), .out_count(cnt_a),
`ifdef MAX_FINDER_STREAM_MIN_EN
        .out_min(min_a), .out_min_idx(midx_a),
`endif
        .out_err(err_a));

    max_finder_stream #(.WIDTH(8), .MAX_LEN(256), .SIGNED(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .in_last(in_last), .out_valid(val_b), .out_ready(out_ready),
        .out_max(max_b), .out_idx(idx_b), .out_count(cnt_b),
`ifdef MAX_FINDER_STREAM_MIN_EN
        .out_min(min_b), .out_min_idx(midx_b),
`endif
        .out_err(err_b));

    max_finder_stream #(.WIDTH(8), .MAX_LEN(4), .SIGNED(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
        .in_data(in_data), .in_last(in_last), .out_valid(val_c), .out_ready(out_ready),
        .out_max(max_c), .out_idx(idx_c), .out_count(cnt_c),
`ifdef MAX_FINDER_STREAM_MIN_EN
        .out_min(min_c), .out_min_idx(midx_c),
`endif
        .out_err(err_c));

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] frame_q[$];

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // Frame result from the list of beats: only the first maxlen beats compete.
    function automatic void model(input bit sgn, input int maxlen,
                                  output int mx, output int mi, output int mn,
                                  output int mni, output int cnt, output int er);
        int n;
        int v;
        n = frame_q.size();
        mx = 0; mi = 0; mn = 0; mni = 0;
        for (int i = 0; i < n && i < maxlen; i++) begin
            v = int'(frame_q[i]);
            if (sgn && v >= 128) v = v - 256;
            if (i == 0 || v > mx) begin mx = v; mi = i; end
            if (i == 0 || v < mn) begin mn = v; mni = i; end
        end
        cnt = (n < maxlen) ? n : maxlen;
        er  = (n > maxlen) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares every instance's result fields against the model.
    task automatic check_results(input string tag);
        int mx, mi, mn, mni, cnt, er;
        model(1'b0, 256, mx, mi, mn, mni, cnt, er);
        check({tag, "_a_max"}, 32'(max_a), 32'(mx & 255));
        check({tag, "_a_idx"}, 32'(idx_a), 32'(mi));
        check({tag, "_a_cnt"}, 32'(cnt_a), 32'(cnt));
        check({tag, "_a_err"}, 32'(err_a), 32'(er));
`ifdef MAX_FINDER_STREAM_MIN_EN
        check({tag, "_a_min"}, 32'(min_a), 32'(mn & 255));
        check({tag, "_a_midx"}, 32'(midx_a), 32'(mni));
`endif
        model(1'b1, 256, mx, mi, mn, mni, cnt, er);
        check({tag, "_b_max"}, 32'(max_b), 32'(mx & 255));
        check({tag, "_b_idx"}, 32'(idx_b), 32'(mi));
        check({tag, "_b_cnt"}, 32'(cnt_b), 32'(cnt));
        check({tag, "_b_err"}, 32'(err_b), 32'(er));
`ifdef MAX_FINDER_STREAM_MIN_EN
        check({tag, "_b_min"}, 32'(min_b), 32'(mn & 255));
        check({tag, "_b_midx"}, 32'(midx_b), 32'(mni));
`endif
        model(1'b0, 4, mx, mi, mn, mni, cnt, er);
        check({tag, "_c_max"}, 32'(max_c), 32'(mx & 255));
        check({tag, "_c_idx"}, 32'(idx_c), 32'(mi));
        check({tag, "_c_cnt"}, 32'(cnt_c), 32'(cnt));
        check({tag, "_c_err"}, 32'(err_c), 32'(er));
`ifdef MAX_FINDER_STREAM_MIN_EN
        check({tag, "_c_min"}, 32'(min_c), 32'(mn & 255));
        check({tag, "_c_midx"}, 32'(midx_c), 32'(mni));
`endif
    endtask

    task automatic check_hs(input string tag, input logic rdy, input logic val);
        check({tag, "_rdy"}, 32'({rdy_a, rdy_b, rdy_c}), 32'({rdy, rdy, rdy}));
        check({tag, "_val"}, 32'({val_a, val_b, val_c}), 32'({val, val, val}));
    endtask

    task automatic check_zero(input string tag);
        check_hs(tag, 1'b0, 1'b0);
        check({tag, "_max"}, 32'({max_a, max_b, max_c}), 32'(0));
        check({tag, "_idx"}, 32'({idx_a, idx_b, idx_c}), 32'(0));
        check({tag, "_cnt"}, 32'({cnt_a, cnt_b, cnt_c}), 32'(0));
        check({tag, "_err"}, 32'({err_a, err_b, err_c}), 32'(0));
`ifdef MAX_FINDER_STREAM_MIN_EN
        check({tag, "_min"}, 32'({min_a, min_b, min_c, midx_a, midx_b, midx_c}), 32'(0));
`endif
    endtask

    // Streams frame_q with random bubbles, then checks the result one cycle later.
    task automatic send_frame(input string tag, input int gap_pct);
        int n;
        n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                in_valid  = 1'b0;
                in_data   = 8'($urandom);
                in_last   = 1'($urandom);
                out_ready = 1'($urandom);
                tick();
            end
            check_hs({tag, "_beat"}, 1'b1, 1'b0);
            in_valid  = 1'b1;
            in_data   = frame_q[i];
            in_last   = (i == n - 1);
            out_ready = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_hs({tag, "_done"}, 1'b0, 1'b1);
        check_results(tag);
    endtask

    // Holds the result under backpressure with ignored input traffic, then consumes it.
    task automatic finish_result(input string tag, input int hold);
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            tick();
            check_hs({tag, "_hold"}, 1'b0, 1'b1);
            check_results({tag, "_hold"});
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'($urandom);
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        check_hs({tag, "_free"}, 1'b1, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = 8'd0;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        #1;
        check_hs("reset_rel", 1'b1, 1'b0);

        frame_q = '{8'd3, 8'd9, 8'd2, 8'd9};
        send_frame("tie", 0);
        check("tie_max", 32'(max_a), 32'd9);
        check("tie_idx", 32'(idx_a), 32'd1);
        check("tie_cnt", 32'(cnt_a), 32'd4);
        finish_result("tie", 0);

        frame_q = '{8'h80, 8'h7F, 8'hFF};
        send_frame("sgn", 0);
        check("sgn_u_max", 32'(max_a), 32'hFF);
        check("sgn_u_idx", 32'(idx_a), 32'd2);
        check("sgn_s_max", 32'(max_b), 32'h7F);
        check("sgn_s_idx", 32'(idx_b), 32'd1);
        finish_result("sgn", 5);

        frame_q = '{8'd5};
        send_frame("single", 0);
        check("single_max", 32'(max_a), 32'd5);
        check("single_cnt", 32'(cnt_a), 32'd1);
        finish_result("single", 0);

        frame_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd0};
        send_frame("ovf", 0);
        check("ovf_c_max", 32'(max_c), 32'd4);
        check("ovf_c_idx", 32'(idx_c), 32'd3);
        check("ovf_c_cnt", 32'(cnt_c), 32'd4);
        check("ovf_c_err", 32'(err_c), 32'd1);
        finish_result("ovf", 1);

        in_valid = 1'b1; in_data = 8'd7; tick();
        in_data = 8'd8; tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_rdy_low", 32'({rdy_a, rdy_b, rdy_c}), 32'(0));
        tick();
        check_zero("midrst");
        rst_n = 1'b1;
        #1;
        check_hs("midrst_rel", 1'b1, 1'b0);
        frame_q = '{8'd2, 8'd1};
        send_frame("after_rst", 0);
        check("after_rst_max", 32'(max_a), 32'd2);
        check("after_rst_idx", 32'(idx_a), 32'd0);
        check("after_rst_cnt", 32'(cnt_a), 32'd2);
        finish_result("after_rst", 0);

`ifdef MAX_FINDER_STREAM_MIN_EN
        frame_q = '{8'd4, 8'd1, 8'd7, 8'd1};
        send_frame("minmax", 0);
        check("minmax_min", 32'(min_a), 32'd1);
        check("minmax_midx", 32'(midx_a), 32'd1);
        check("minmax_max", 32'(max_a), 32'd7);
        check("minmax_idx", 32'(idx_a), 32'd2);
        finish_result("minmax", 0);
`endif

        for (int f = 0; f < 40; f++) begin
            int len;
            logic [7:0] pick [4];
            pick[0] = 8'h00; pick[1] = 8'h7F; pick[2] = 8'h80; pick[3] = 8'hFF;
            len = $urandom_range(1, 8);
            frame_q.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) frame_q.push_back(pick[$urandom_range(0, 3)]);
                else frame_q.push_back(8'($urandom));
            end
            send_frame($sformatf("rnd%0d", f), 25);
            finish_result($sformatf("rnd%0d", f), $urandom_range(0, 3));
        end

        frame_q.delete();
        for (int i = 0; i < 256; i++) frame_q.push_back(8'($urandom_range(0, 200)));
        frame_q[255] = 8'hF0;
        send_frame("len256", 5);
        finish_result("len256", 1);

        frame_q.delete();
        for (int i = 0; i < 258; i++) frame_q.push_back(8'($urandom_range(0, 200)));
        frame_q[256] = 8'hFE;
        send_frame("len258", 5);
        finish_result("len258", 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
